mulu_m2q2_arb: RTL

Two-requester round-robin scheduler that shares one mulu_m2q2 unsigned multiplier instance.
- Accepts operand pairs over a req/gnt handshake and registers them onto the multiplier inputs.
- Holds those inputs stable for LATENCY cycles, then captures the product.
- Returns the product and its owner over a valid/ready handshake.
- Sits between datapath clients and the multiplier; the multiplier itself stays combinational and unclocked.

---
 rtl/mulu_m2q2_arb_if.sv | 36 +++
 rtl/mulu_m2q2_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mulu_m2q2_arb_if.sv
// Handshake bundle between two multiply requesters, the shared combinational
// multiplier and the result consumer on one side, and the arbiter on the other.
interface mulu_m2q2_arb_if #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 8,
    parameter int P_WIDTH = X_WIDTH + Y_WIDTH
);
    logic               req0;
    logic [X_WIDTH-1:0] x0;
    logic [Y_WIDTH-1:0] y0;
    logic               gnt0;
    logic               req1;
    logic [X_WIDTH-1:0] x1;
    logic [Y_WIDTH-1:0] y1;
    logic               gnt1;
    logic [X_WIDTH-1:0] mx;
    logic [Y_WIDTH-1:0] my;
    logic [P_WIDTH-1:0] mp;
    logic [P_WIDTH-1:0] p_out;
    logic               p_owner;
    logic               p_valid;
    logic               p_ready;
    logic               busy;

    // Environment side: requesters, multiplier product and result consumer.
    modport master (
        output req0, x0, y0, req1, x1, y1, mp, p_ready,
        input  gnt0, gnt1, mx, my, p_out, p_owner, p_valid, busy
    );

    // Arbiter side.
    modport slave (
        input  req0, x0, y0, req1, x1, y1, mp, p_ready,
        output gnt0, gnt1, mx, my, p_out, p_owner, p_valid, busy
    );
endinterface

// File: rtl/mulu_m2q2_arb.sv
// Round-robin scheduler sharing one combinational mulu_m2q2 multiplier between
// two requesters; operands are registered, held for LATENCY cycles, then the product is captured.
module mulu_m2q2_arb #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 8,
    parameter int P_WIDTH = X_WIDTH + Y_WIDTH,
    parameter int LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mulu_m2q2_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         cnt_r;
    logic [3:0]         cnt_nxt_s;
    logic               last_r;
    logic               last_nxt_s;
    logic               gnt0_r;
    logic               gnt0_nxt_s;
    logic               gnt1_r;
    logic               gnt1_nxt_s;
    logic [X_WIDTH-1:0] mx_r;
    logic [X_WIDTH-1:0] mx_nxt_s;
    logic [Y_WIDTH-1:0] my_r;
    logic [Y_WIDTH-1:0] my_nxt_s;
    logic [P_WIDTH-1:0] p_out_r;
    logic [P_WIDTH-1:0] p_out_nxt_s;
    logic               p_owner_r;
    logic               p_owner_nxt_s;
    logic               p_valid_r;
    logic               p_valid_nxt_s;
    logic               busy_r;
    logic               any_req_s;
    logic               win_s;

    // Winner selection: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        any_req_s = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            win_s = ~last_r;
        end else if (bus.req1) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_CALC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CALC;
                end
            end
            ST_DONE: begin
                if (bus.p_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values; everything holds unless the state acts on it.
    always_comb begin
        cnt_nxt_s     = cnt_r;
        last_nxt_s    = last_r;
        gnt0_nxt_s    = 1'b0;
        gnt1_nxt_s    = 1'b0;
        mx_nxt_s      = mx_r;
        my_nxt_s      = my_r;
        p_out_nxt_s   = p_out_r;
        p_owner_nxt_s = p_owner_r;
        p_valid_nxt_s = p_valid_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    if (win_s) begin
                        mx_nxt_s   = bus.x1;
                        my_nxt_s   = bus.y1;
                        gnt1_nxt_s = 1'b1;
                    end else begin
                        mx_nxt_s   = bus.x0;
                        my_nxt_s   = bus.y0;
                        gnt0_nxt_s = 1'b1;
                    end
                    p_owner_nxt_s = win_s;
                    cnt_nxt_s     = CNT_LOAD;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_CALC: begin
                if (cnt_r == 4'd0) begin
                    p_out_nxt_s   = bus.mp;
                    p_valid_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_DONE: begin
                if (bus.p_ready) begin
                    p_valid_nxt_s = 1'b0;
                    last_nxt_s    = p_owner_r;
                end else begin
                    p_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                p_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath; last resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= 4'd0;
            last_r    <= 1'b1;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            mx_r      <= '0;
            my_r      <= '0;
            p_out_r   <= '0;
            p_owner_r <= 1'b0;
            p_valid_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            last_r    <= last_nxt_s;
            gnt0_r    <= gnt0_nxt_s;
            gnt1_r    <= gnt1_nxt_s;
            mx_r      <= mx_nxt_s;
            my_r      <= my_nxt_s;
            p_out_r   <= p_out_nxt_s;
            p_owner_r <= p_owner_nxt_s;
            p_valid_r <= p_valid_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.mx      = mx_r;
    assign bus.my      = my_r;
    assign bus.p_out   = p_out_r;
    assign bus.p_owner = p_owner_r;
    assign bus.p_valid = p_valid_r;
    assign bus.busy    = busy_r;

    mulu_m2q2_arb_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .gnt0    (gnt0_r),
        .gnt1    (gnt1_r),
        .p_valid (p_valid_r),
        .busy    (busy_r)
    );
endmodule

// Protocol properties of the arbiter outputs.
module mulu_m2q2_arb_chk (
    input logic clk,
    input logic rst_n,
    input logic gnt0,
    input logic gnt1,
    input logic p_valid,
    input logic busy
);
    a_gnt_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(gnt0 && gnt1));
    a_gnt_pulse: assert property (@(posedge clk) disable iff (!rst_n)
        (gnt0 || gnt1) |=> !(gnt0 || gnt1));
    a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
        p_valid |-> busy);
endmodule
